// File: rtl/feature_fetcher.sv
// Feature-buffer write-path front end: turns a load command plus a word stream
// into demux write strobes and tracks ping-pong bank occupancy.
`timescale 1ns/1ps
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module feature_fetcher #(
  parameter int unsigned DATA_BUS_WIDTH = `DATA_BUS_WIDTH,
  parameter int unsigned ADDR_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_bank,
  input  logic [ADDR_WIDTH-1:0]     cmd_base_addr,
  input  logic [ADDR_WIDTH-1:0]     cmd_len_m1,
  input  logic [DATA_BUS_WIDTH-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [1:0]                bank_release,
  output logic                      fetcher_to_mem,
  output logic [ADDR_WIDTH-1:0]     wr_feature_addr,
  output logic [DATA_BUS_WIDTH-1:0] wr_feature_data,
  output logic                      wr_feature_sel,
  output logic                      load_done,
  output logic [1:0]                bank_full,
  output logic                      busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic                      bank_q, bank_d;
  logic [ADDR_WIDTH-1:0]     base_q, base_d;
  logic [ADDR_WIDTH-1:0]     len_q, len_d;
  logic [ADDR_WIDTH-1:0]     count_q, count_d;
  logic                      wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
  logic                      sel_q, sel_d;
  logic                      done_q, done_d;
  logic [1:0]                full_q, full_d;
  logic [1:0]                full_set;

  logic cmd_fire;
  logic beat;
  logic last_beat;

  // Handshake decodes; cmd_ready looks at the requested bank's occupancy directly.
  assign cmd_ready = (state_q == ST_IDLE) && !full_q[cmd_bank];
  assign s_ready   = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign beat      = s_valid && s_ready;
  assign last_beat = beat && (count_q == len_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_fire) state_d = ST_LOAD;
      ST_LOAD: if (last_beat) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    bank_d   = bank_q;
    base_d   = base_q;
    len_d    = len_q;
    count_d  = count_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    full_set = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          bank_d  = cmd_bank;
          base_d  = cmd_base_addr;
          len_d   = cmd_len_m1;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (beat) begin
          wr_en_d = 1'b1;
          addr_d  = base_q + count_q;
          data_d  = s_data;
          sel_d   = bank_q;
          count_d = count_q + ADDR_WIDTH'(1);
        end
        if (last_beat) begin
          done_d           = 1'b1;
          full_set[bank_q] = 1'b1;
        end
      end
      // Keep asserting the set through DONE so a coincident release cannot clear it.
      ST_DONE: full_set[bank_q] = 1'b1;
      default: ;
    endcase
    full_d = (full_q & ~bank_release) | full_set;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q  <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 2'b00;
    end else begin
      bank_q  <= bank_d;
      base_q  <= base_d;
      len_q   <= len_d;
      count_q <= count_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      full_q  <= full_d;
    end
  end

  assign fetcher_to_mem  = wr_en_q;
  assign wr_feature_addr = addr_q;
  assign wr_feature_data = data_q;
  assign wr_feature_sel  = sel_q;
  assign load_done       = done_q;
  assign bank_full       = full_q;

endmodule

// File: tb/tb_feature_fetcher.sv
// Scoreboard bench for feature_fetcher: directed loads push expected writes,
// a negedge monitor pops and compares every write strobe.
`timescale 1ns/1ps

module tb_feature_fetcher;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_bank;
  logic [7:0]    cmd_base_addr;
  logic [7:0]    cmd_len_m1;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [1:0]    bank_release;
  logic          fetcher_to_mem;
  logic [7:0]    wr_feature_addr;
  logic [DW-1:0] wr_feature_data;
  logic          wr_feature_sel;
  logic          load_done;
  logic [1:0]    bank_full;
  logic          busy;

  feature_fetcher #(.DATA_BUS_WIDTH(DW), .ADDR_WIDTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_bank       (cmd_bank),
    .cmd_base_addr  (cmd_base_addr),
    .cmd_len_m1     (cmd_len_m1),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .bank_release   (bank_release),
    .fetcher_to_mem (fetcher_to_mem),
    .wr_feature_addr(wr_feature_addr),
    .wr_feature_data(wr_feature_data),
    .wr_feature_sel (wr_feature_sel),
    .load_done      (load_done),
    .bank_full      (bank_full),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    addr;
    logic [DW-1:0] data;
    logic          sel;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   done_seen = 0;
  int   d0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe must match the oldest expected write; load_done rides with the last one.
  always @(negedge clk) begin
    if (load_done) done_seen++;
    if (fetcher_to_mem) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(fetcher_to_mem), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_feature_addr), 32'(mon_e.addr));
        check("wr_data", wr_feature_data, mon_e.data);
        check("wr_sel", 32'(wr_feature_sel), 32'(mon_e.sel));
        check("done_with_last", 32'(load_done), 32'(mon_e.last));
      end
    end else if (load_done) begin
      check("done_without_write", 32'(load_done), 0);
    end
  end

  task automatic issue_cmd(input logic bank, input logic [7:0] base, input logic [7:0] len_m1);
    int waited;
    waited        = 0;
    cmd_valid     = 1'b1;
    cmd_bank      = bank;
    cmd_base_addr = base;
    cmd_len_m1    = len_m1;
    #1;
    while (!cmd_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
    check("s_ready_after_accept", 32'(s_ready), 1);
  endtask

  task automatic send_beats(input logic bank, input logic [7:0] base, input int n,
                            input int len_m1, input logic [31:0] dbase, input bit gaps);
    int waited;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        s_valid = 1'b0;
        s_data  = 32'hDEAD_BEEF;
        tick();
      end
      s_valid = 1'b1;
      s_data  = 32'(dbase + 32'(i));
      waited  = 0;
      while (!s_ready && waited < 5) begin
        tick();
        waited++;
      end
      if (!s_ready) check("s_ready_timeout", 32'(s_ready), 1);
      exp_q.push_back('{addr: 8'(base + 8'(i)), data: 32'(dbase + 32'(i)),
                        sel: bank, last: (i == len_m1)});
      tick();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    cmd_valid     = 1'b0;
    cmd_bank      = 1'b0;
    cmd_base_addr = '0;
    cmd_len_m1    = '0;
    s_data        = '0;
    s_valid       = 1'b0;
    bank_release  = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobe", 32'(fetcher_to_mem), 0);
    check("rst_bank_full", 32'(bank_full), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_load_done", 32'(load_done), 0);
    rst_n = 1'b1;
    tick();
    check("idle_cmd_ready", 32'(cmd_ready), 1);
    check("idle_s_ready", 32'(s_ready), 0);

    // Basic load: bank 0, addr 0..3
    issue_cmd(1'b0, 8'h00, 8'd3);
    send_beats(1'b0, 8'h00, 4, 3, 32'hA000_0000, 1'b0);
    check("basic_bank_full_in_done", 32'(bank_full), 1);
    check("basic_busy_in_done", 32'(busy), 1);
    tick();
    check("basic_busy_idle", 32'(busy), 0);
    check("basic_done_count", 32'(done_seen), 1);

    // Back-pressure gaps on the same command
    bank_release = 2'b01;
    tick();
    bank_release = 2'b00;
    check("release_bank0", 32'(bank_full), 0);
    issue_cmd(1'b0, 8'h00, 8'd3);
    send_beats(1'b0, 8'h00, 4, 3, 32'hB000_0000, 1'b1);
    check("gaps_bank_full", 32'(bank_full), 1);
    tick();

    // Ping-pong: full bank 0 refuses, bank 1 accepted
    cmd_valid     = 1'b1;
    cmd_bank      = 1'b0;
    cmd_base_addr = 8'h55;
    cmd_len_m1    = 8'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("cmd_ready_full_bank", 32'(cmd_ready), 0);
      tick();
    end
    check("no_accept_full_bank", 32'(busy), 0);
    issue_cmd(1'b1, 8'h10, 8'd1);
    send_beats(1'b1, 8'h10, 2, 1, 32'hC000_0000, 1'b0);
    check("pingpong_bank_full", 32'(bank_full), 3);
    tick();
    bank_release = 2'b01;
    tick();
    bank_release = 2'b00;
    check("release_bank0_of_two", 32'(bank_full), 2);
    cmd_valid = 1'b1;
    cmd_bank  = 1'b0;
    #1;
    check("cmd_ready_after_release", 32'(cmd_ready), 1);

    // Wrap and max length: 256 words from 0xF0
    d0 = done_seen;
    issue_cmd(1'b0, 8'hF0, 8'hFF);
    send_beats(1'b0, 8'hF0, 256, 255, 32'hE000_0000, 1'b0);
    check("wrap_bank_full", 32'(bank_full), 3);
    tick();
    check("wrap_done_once", 32'(done_seen - d0), 1);

    // Reset mid-load (bank 1 still full beforehand)
    bank_release = 2'b01;
    tick();
    bank_release = 2'b00;
    check("pre_reset_bank_full", 32'(bank_full), 2);
    issue_cmd(1'b0, 8'h40, 8'd7);
    send_beats(1'b0, 8'h40, 2, 7, 32'h4000_0000, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobe", 32'(fetcher_to_mem), 0);
    check("mid_rst_addr", 32'(wr_feature_addr), 0);
    check("mid_rst_data", wr_feature_data, 0);
    check("mid_rst_sel", 32'(wr_feature_sel), 0);
    check("mid_rst_load_done", 32'(load_done), 0);
    check("mid_rst_bank_full", 32'(bank_full), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_s_ready", 32'(s_ready), 0);
    check("mid_rst_pending_writes", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    issue_cmd(1'b0, 8'h80, 8'd0);
    send_beats(1'b0, 8'h80, 1, 0, 32'h8000_0000, 1'b0);
    check("post_rst_bank_full", 32'(bank_full), 1);
    tick();

    // Set/release collision: release bank 1 during its DONE cycle
    issue_cmd(1'b1, 8'h20, 8'd1);
    send_beats(1'b1, 8'h20, 2, 1, 32'h2000_0000, 1'b0);
    bank_release = 2'b10;
    check("collision_in_done", 32'(bank_full), 3);
    tick();
    bank_release = 2'b00;
    check("collision_bank_full", 32'(bank_full), 3);
    tick();
    tick();

    check("all_writes_seen", 32'(exp_q.size()), 0);
    check("total_done_pulses", 32'(done_seen), 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
